// File: rtl/chip8_pkg.sv
// Shared constants for the CHIP-8 fetch path.
//   ADDR_W   : byte address / program counter width
//   OPCODE_W : instruction width (two bytes, big-endian)
//   HI_A..VALID : fetch FSM state encoding (3 bits)
package chip8_pkg;
  localparam int ADDR_W   = 8;
  localparam int OPCODE_W = 16;

  // Each byte takes an address cycle (_A) and a data cycle (_D) so that both
  // combinational and 1-cycle registered memories return data in time.
  localparam logic [2:0] HI_A  = 3'd0;
  localparam logic [2:0] HI_D  = 3'd1;
  localparam logic [2:0] LO_A  = 3'd2;
  localparam logic [2:0] LO_D  = 3'd3;
  localparam logic [2:0] VALID = 3'd4;
endpackage

// File: rtl/chip8_pc_unit.sv
// Program counter register for the CHIP-8 fetch unit.
//   clk, rst    : clock, synchronous active-high reset (pc <= RESET_PC)
//   load        : jump, pc <= load_value (wins over advance)
//   load_value  : jump target
//   advance     : an opcode was consumed, pc <= pc + 2
//   skip        : with advance, pc <= pc + 4 instead
//   pc          : current program counter
module chip8_pc_unit
  import chip8_pkg::*;
#(
  parameter int                AW       = 8,
  parameter logic [AW-1:0]     RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW-1:0] load_value,
  input  logic          advance,
  input  logic          skip,
  output logic [AW-1:0] pc
);

  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_d;

  // Additions wrap naturally at AW bits.
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_value;
    end else if (advance) begin
      pc_d = skip ? (pc_q + AW'(4)) : (pc_q + AW'(2));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/chip8_fetch_unit.sv
// CHIP-8 instruction fetch stage: reads two bytes per instruction from an
// 8-bit memory, assembles them big-endian and presents them to the decoder
// on a valid/ready handshake. Owns the program counter.
//   clk, rst         : clock, synchronous active-high reset
//   mem_addr, mem_rd : byte address and read request to memory
//   mem_read_data    : byte returned by memory
//   opcode, opcode_pc, opcode_valid, opcode_ready : decoder handshake
//   pc_load, pc_load_value : jump from execute (highest priority after rst)
//   pc_skip          : skip next instruction, honoured only on a transfer
module chip8_fetch_unit
  import chip8_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter int         ADDR_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_rd,
  input  logic [7:0]          mem_read_data,
  output logic [OPCODE_W-1:0] opcode,
  output logic [ADDR_W-1:0]   opcode_pc,
  output logic                opcode_valid,
  input  logic                opcode_ready,
  input  logic                pc_load,
  input  logic [ADDR_W-1:0]   pc_load_value,
  input  logic                pc_skip
);

  localparam logic [ADDR_W-1:0] RESET_PC_W = ADDR_W'(RESET_PC);

  logic [2:0]          state_q, state_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [ADDR_W-1:0]   opcode_pc_q, opcode_pc_d;
  logic                opcode_valid_q, opcode_valid_d;
  logic [ADDR_W-1:0]   pc;
  logic [ADDR_W-1:0]   pc_plus1;
  logic                transfer;

  assign transfer = opcode_valid_q && opcode_ready;
  assign pc_plus1 = pc + ADDR_W'(1);

  chip8_pc_unit #(
    .AW       (ADDR_W),
    .RESET_PC (RESET_PC_W)
  ) u_pc (
    .clk        (clk),
    .rst        (rst),
    .load       (pc_load),
    .load_value (pc_load_value),
    .advance    (transfer),
    .skip       (pc_skip),
    .pc         (pc)
  );

  always_comb begin
    state_d        = state_q;
    opcode_d       = opcode_q;
    opcode_pc_d    = opcode_pc_q;
    opcode_valid_d = opcode_valid_q;
    case (state_q)
      HI_A:  state_d = HI_D;
      HI_D: begin
        opcode_d[15:8] = mem_read_data;
        state_d        = LO_A;
      end
      LO_A:  state_d = LO_D;
      LO_D: begin
        opcode_d[7:0]  = mem_read_data;
        opcode_pc_d    = pc;
        opcode_valid_d = 1'b1;
        state_d        = VALID;
      end
      VALID: begin
        if (transfer) begin
          opcode_valid_d = 1'b0;
          state_d        = HI_A;
        end
      end
      default: state_d = HI_A;
    endcase
    // A jump aborts whatever is in flight; a byte captured this cycle is
    // dropped by keeping the previous opcode register contents.
    if (pc_load) begin
      state_d        = HI_A;
      opcode_d       = opcode_q;
      opcode_pc_d    = opcode_pc_q;
      opcode_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= HI_A;
      opcode_q       <= '0;
      opcode_pc_q    <= RESET_PC_W;
      opcode_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      opcode_q       <= opcode_d;
      opcode_pc_q    <= opcode_pc_d;
      opcode_valid_q <= opcode_valid_d;
    end
  end

  // Address is held for both cycles of each byte so data is stable at the
  // end of the second; the memory is idle while holding a presented opcode.
  always_comb begin
    mem_addr = pc;
    mem_rd   = 1'b0;
    if (rst) begin
      mem_addr = RESET_PC_W;
    end else begin
      case (state_q)
        HI_A, HI_D: begin
          mem_addr = pc;
          mem_rd   = 1'b1;
        end
        LO_A, LO_D: begin
          mem_addr = pc_plus1;
          mem_rd   = 1'b1;
        end
        default: begin
          mem_addr = pc;
          mem_rd   = 1'b0;
        end
      endcase
    end
  end

  assign opcode       = opcode_q;
  assign opcode_pc    = opcode_pc_q;
  assign opcode_valid = opcode_valid_q;

endmodule

// File: tb/tb_chip8_fetch_unit.sv
// Self-checking bench for chip8_fetch_unit: directed scenarios followed by
// randomized handshake/jump/skip/reset traffic, checked every cycle against
// a transaction-level model (current PC plus cycles since the fetch began).
module tb_chip8_fetch_unit;

  localparam logic [7:0] RESET_PC = 8'h00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_read_data = 8'h00;
  logic [15:0] opcode;
  logic [7:0]  opcode_pc;
  logic        opcode_valid;
  logic        opcode_ready = 1'b0;
  logic        pc_load = 1'b0;
  logic [7:0]  pc_load_value = 8'h00;
  logic        pc_skip = 1'b0;

  logic [7:0]  mem [256];

  int checks = 0;
  int errors = 0;

  // Model: m_pc is the address of the instruction being fetched/presented,
  // m_age counts edges since that fetch started (4 or more = presented).
  logic [7:0]  m_pc = RESET_PC;
  int          m_age = 0;

  chip8_fetch_unit #(
    .RESET_PC (RESET_PC),
    .ADDR_W   (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_addr      (mem_addr),
    .mem_rd        (mem_rd),
    .mem_read_data (mem_read_data),
    .opcode        (opcode),
    .opcode_pc     (opcode_pc),
    .opcode_valid  (opcode_valid),
    .opcode_ready  (opcode_ready),
    .pc_load       (pc_load),
    .pc_load_value (pc_load_value),
    .pc_skip       (pc_skip)
  );

  always #5 clk = ~clk;

  // 1-cycle registered read memory.
  always @(posedge clk) mem_read_data <= mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic       r_rst, r_load, r_ready, r_skip;
    logic [7:0] r_val;
    logic       presented;
    logic [7:0] exp_addr;
    r_rst   = rst;
    r_load  = pc_load;
    r_ready = opcode_ready;
    r_skip  = pc_skip;
    r_val   = pc_load_value;
    presented = (m_age >= 4);
    @(posedge clk);
    #1;
    if (r_rst) begin
      m_pc  = RESET_PC;
      m_age = 0;
    end else if (r_load) begin
      m_pc  = r_val;
      m_age = 0;
    end else if (presented && r_ready) begin
      m_pc  = m_pc + (r_skip ? 8'd4 : 8'd2);
      m_age = 0;
    end else begin
      m_age = m_age + 1;
    end

    chk("valid", opcode_valid, (m_age >= 4));
    chk("mem_rd", mem_rd, (!r_rst && m_age < 4));
    if (r_rst)                     exp_addr = RESET_PC;
    else if (m_age == 2 || m_age == 3) exp_addr = m_pc + 8'd1;
    else                           exp_addr = m_pc;
    chk("mem_addr", mem_addr, exp_addr);
    if (m_age >= 4) begin
      chk("opcode", opcode, {mem[m_pc], mem[8'(m_pc + 8'd1)]});
      chk("opcode_pc", opcode_pc, m_pc);
    end
    if (r_rst) begin
      chk("rst_opcode", opcode, 16'h0000);
      chk("rst_opcode_pc", opcode_pc, RESET_PC);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (opcode_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk(tag, opcode_valid, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h00] = 8'h12; mem[8'h01] = 8'h34;
    mem[8'h02] = 8'hAB; mem[8'h03] = 8'hCD;
    mem[8'hFF] = 8'h6A;

    // Reset
    rst = 1'b1;
    step(); step();
    chk("reset_valid", opcode_valid, 1'b0);
    chk("reset_mem_rd", mem_rd, 1'b0);

    // Basic fetch: valid in the 5th cycle after release
    rst = 1'b0; opcode_ready = 1'b1;
    repeat (3) step();
    chk("basic_not_yet", opcode_valid, 1'b0);
    step();
    chk("basic_valid", opcode_valid, 1'b1);
    chk("basic_opcode", opcode, 16'h1234);
    chk("basic_pc", opcode_pc, 8'h00);
    step();
    opcode_ready = 1'b0;
    chk("next_addr", mem_addr, 8'h02);

    // Backpressure
    repeat (3) step();
    repeat (10) step();
    chk("bp_opcode", opcode, 16'hABCD);
    chk("bp_valid", opcode_valid, 1'b1);
    chk("bp_mem_rd", mem_rd, 1'b0);
    opcode_ready = 1'b1;
    step();
    opcode_ready = 1'b0;
    chk("bp_one_transfer", opcode_valid, 1'b0);
    wait_valid("wait_04");
    chk("bp_next_pc", opcode_pc, 8'h04);

    // Skip on transfer
    opcode_ready = 1'b1; pc_skip = 1'b1;
    step();
    opcode_ready = 1'b0; pc_skip = 1'b0;
    wait_valid("wait_08");
    chk("skip_pc", opcode_pc, 8'h08);

    // Skip during HI_D is ignored
    opcode_ready = 1'b1;
    step();
    opcode_ready = 1'b0;
    step();
    pc_skip = 1'b1; opcode_ready = 1'b1;
    step();
    pc_skip = 1'b0; opcode_ready = 1'b0;
    wait_valid("wait_0a");
    chk("skip_ignored_pc", opcode_pc, 8'h0A);

    // Jump during LO_A
    opcode_ready = 1'b1;
    step();
    opcode_ready = 1'b0;
    step(); step();
    pc_load = 1'b1; pc_load_value = 8'h40;
    step();
    pc_load = 1'b0;
    chk("jump_valid", opcode_valid, 1'b0);
    chk("jump_addr", mem_addr, 8'h40);
    wait_valid("wait_40");
    chk("jump_pc", opcode_pc, 8'h40);

    // Wrap at the top of memory
    mem[8'h00] = 8'h05;
    pc_load = 1'b1; pc_load_value = 8'hFF;
    step();
    pc_load = 1'b0;
    wait_valid("wait_ff");
    chk("wrap_opcode", opcode, 16'h6A05);
    chk("wrap_pc", opcode_pc, 8'hFF);
    opcode_ready = 1'b1;
    step();
    opcode_ready = 1'b0;
    wait_valid("wait_01");
    chk("wrap_next_pc", opcode_pc, 8'h01);

    // Reset during LO_D
    opcode_ready = 1'b1;
    step();
    opcode_ready = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_valid", opcode_valid, 1'b0);
    chk("midrst_opcode", opcode, 16'h0000);
    begin
      int n = 0;
      while (opcode_valid !== 1'b1 && n < 20) begin
        step();
        n++;
      end
      chk("midrst_latency", n, 4);
      chk("midrst_pc", opcode_pc, RESET_PC);
    end

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      opcode_ready  = 1'($urandom);
      pc_skip       = 1'($urandom);
      pc_load       = ($urandom_range(0, 15) == 0);
      pc_load_value = 8'($urandom);
      rst           = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0; pc_load = 1'b0; pc_skip = 1'b0; opcode_ready = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
